// File: rtl/mu0_mem_pkg.sv
// Shared types and default sizes for the MU0 block-RAM arbiter slice.
// Port 0 is the CPU, port 1 is the debug/loader interface.
package mu0_mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef logic port_id_t;

    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_DBG = 1'b1;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter for the RAM: round-robin by default, or port 0 always
// wins when FIXED_PRIORITY is set. Grants are forced off while rst is high.
module rr_arb2
    import mu0_mem_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_id_t last_grant;

    // Reset to port 1 so that port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= PORT_DBG;
        end else if (|gnt) begin
            last_grant <= port_id_t'(gnt[1]);
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (req == 2'b11) begin
                if (FIXED_PRIORITY || (last_grant == PORT_DBG)) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter_2port.sv
// Shares one single-port block RAM between the CPU and the debug port:
// one access per cycle, read data returned a cycle later with a per-port strobe.
module ram_arbiter_2port
    import mu0_mem_pkg::*;
#(
    parameter int ADDR_W         = mu0_mem_pkg::ADDR_W,
    parameter int DATA_W         = mu0_mem_pkg::DATA_W,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write,
    output logic              ram_read,
    output logic [DATA_W-1:0] ram_writedata,
    input  logic [DATA_W-1:0] ram_readdata
);

    logic [1:0] gnt;
    logic       sel_write;
    logic       rd_pend;
    port_id_t   rd_owner;

    rr_arb2 #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req ({p1_req, p0_req}),
        .gnt (gnt)
    );

    // With no grant the RAM still sees port 0's fields, but no strobe.
    always_comb begin
        ram_address   = p0_addr;
        ram_writedata = p0_wdata;
        sel_write     = 1'b0;
        if (gnt[1]) begin
            ram_address   = p1_addr;
            ram_writedata = p1_wdata;
            sel_write     = p1_write;
        end else if (gnt[0]) begin
            sel_write = p0_write;
        end
        ram_write = sel_write;
        ram_read  = (|gnt) & ~sel_write;
    end

    assign p0_ack = gnt[0];
    assign p1_ack = gnt[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            rd_owner <= PORT_CPU;
        end else begin
            rd_pend <= ram_read;
            if (ram_read) begin
                rd_owner <= port_id_t'(gnt[1]);
            end
        end
    end

    // Masking with rst drops a return whose read was acked just before reset.
    assign p0_rvalid = rd_pend & ~rst & (rd_owner == PORT_CPU);
    assign p1_rvalid = rd_pend & ~rst & (rd_owner == PORT_DBG);
    assign p0_rdata  = ram_readdata;
    assign p1_rdata  = ram_readdata;

endmodule

// File: tb/tb_ram_arbiter_2port.sv
// Bench for ram_arbiter_2port: a round-robin and a fixed-priority instance,
// each backed by a behavioural 16x4096 block RAM.
module tb_ram_arbiter_2port;
    import mu0_mem_pkg::*;

    typedef struct {
        logic     rst;
        logic     req0;
        mem_req_t q0;
        logic     req1;
        mem_req_t q1;
        logic     ack0;
        logic     ack1;
    } vec_t;

    typedef struct {
        logic        port;
        logic [15:0] data;
        int          due;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_init = 1'b1;
    logic        p0_req = 1'b0, p0_write = 1'b0;
    logic [11:0] p0_addr = '0;
    logic [15:0] p0_wdata = '0;
    logic        p1_req = 1'b0, p1_write = 1'b0;
    logic [11:0] p1_addr = '0;
    logic [15:0] p1_wdata = '0;

    logic        rr_p0_ack, rr_p0_rvalid, rr_p1_ack, rr_p1_rvalid;
    logic [15:0] rr_p0_rdata, rr_p1_rdata;
    logic [11:0] rr_ram_address;
    logic        rr_ram_write, rr_ram_read;
    logic [15:0] rr_ram_writedata, rr_ram_readdata;

    logic        fp_p0_ack, fp_p0_rvalid, fp_p1_ack, fp_p1_rvalid;
    logic [15:0] fp_p0_rdata, fp_p1_rdata;
    logic [11:0] fp_ram_address;
    logic        fp_ram_write, fp_ram_read;
    logic [15:0] fp_ram_writedata, fp_ram_readdata;

    logic [15:0] mem_rr [0:4095];
    logic [15:0] mem_fp [0:4095];
    logic [15:0] shadow [0:4095];

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter_2port #(.FIXED_PRIORITY(1'b0)) dut_rr (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(rr_p0_ack), .p0_rvalid(rr_p0_rvalid), .p0_rdata(rr_p0_rdata),
        .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(rr_p1_ack), .p1_rvalid(rr_p1_rvalid), .p1_rdata(rr_p1_rdata),
        .ram_address(rr_ram_address), .ram_write(rr_ram_write), .ram_read(rr_ram_read),
        .ram_writedata(rr_ram_writedata), .ram_readdata(rr_ram_readdata)
    );

    ram_arbiter_2port #(.FIXED_PRIORITY(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(fp_p0_ack), .p0_rvalid(fp_p0_rvalid), .p0_rdata(fp_p0_rdata),
        .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(fp_p1_ack), .p1_rvalid(fp_p1_rvalid), .p1_rdata(fp_p1_rdata),
        .ram_address(fp_ram_address), .ram_write(fp_ram_write), .ram_read(fp_ram_read),
        .ram_writedata(fp_ram_writedata), .ram_readdata(fp_ram_readdata)
    );

    function automatic logic [15:0] init_val(int i);
        return 16'(i) ^ 16'h5A00;
    endfunction

    // Behavioural block RAMs: synchronous write, registered read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) begin
                mem_rr[i] <= init_val(i);
                mem_fp[i] <= init_val(i);
            end
        end else begin
            if (rr_ram_write) mem_rr[rr_ram_address] <= rr_ram_writedata;
            if (fp_ram_write) mem_fp[fp_ram_address] <= fp_ram_writedata;
        end
        rr_ram_readdata <= mem_rr[rr_ram_address];
        fp_ram_readdata <= mem_fp[fp_ram_address];
    end

    function automatic vec_t mk(logic r, logic r0, logic w0, logic [11:0] a0, logic [15:0] d0,
                                logic r1, logic w1, logic [11:0] a1, logic [15:0] d1,
                                logic k0, logic k1);
        vec_t v;
        v.rst  = r;
        v.req0 = r0;
        v.q0   = '{write: w0, addr: a0, wdata: d0};
        v.req1 = r1;
        v.q1   = '{write: w1, addr: a1, wdata: d1};
        v.ack0 = k0;
        v.ack1 = k1;
        return v;
    endfunction

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        rst      = v.rst;
        p0_req   = v.req0;
        p0_write = v.q0.write;
        p0_addr  = v.q0.addr;
        p0_wdata = v.q0.wdata;
        p1_req   = v.req1;
        p1_write = v.q1.write;
        p1_addr  = v.q1.addr;
        p1_wdata = v.q1.wdata;
    endtask

    // Compares the round-robin instance against the row, then advances the
    // shadow memory and scoreboard using the row's expected grants.
    task automatic checkOutput(input vec_t v, input int cyc);
        logic        ev0, ev1, ew, er;
        logic [15:0] ed;
        logic [11:0] ea;
        sb_t         e;
        @(negedge clk);
        ev0 = 1'b0;
        ev1 = 1'b0;
        ed  = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (!v.rst) begin
                if (e.port) ev1 = 1'b1;
                else        ev0 = 1'b1;
                ed = e.data;
            end
        end
        ew = (v.ack0 & v.q0.write) | (v.ack1 & v.q1.write);
        er = (v.ack0 | v.ack1) & ~ew;
        ea = v.ack1 ? v.q1.addr : v.q0.addr;
        check("p0_ack",      cyc, 32'(rr_p0_ack),      32'(v.ack0));
        check("p1_ack",      cyc, 32'(rr_p1_ack),      32'(v.ack1));
        check("ram_write",   cyc, 32'(rr_ram_write),   32'(ew));
        check("ram_read",    cyc, 32'(rr_ram_read),    32'(er));
        check("ram_address", cyc, 32'(rr_ram_address), 32'(ea));
        check("p0_rvalid",   cyc, 32'(rr_p0_rvalid),   32'(ev0));
        check("p1_rvalid",   cyc, 32'(rr_p1_rvalid),   32'(ev1));
        if (ev0) check("p0_rdata", cyc, 32'(rr_p0_rdata), 32'(ed));
        if (ev1) check("p1_rdata", cyc, 32'(rr_p1_rdata), 32'(ed));
        if (v.ack0) begin
            if (v.q0.write) shadow[v.q0.addr] = v.q0.wdata;
            else sb.push_back('{port: 1'b0, data: shadow[v.q0.addr], due: cyc + 1});
        end
        if (v.ack1) begin
            if (v.q1.write) shadow[v.q1.addr] = v.q1.wdata;
            else sb.push_back('{port: 1'b1, data: shadow[v.q1.addr], due: cyc + 1});
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);

        //            rst  p0: req wr addr    wdata       p1: req wr addr    wdata       ack0 ack1
        vecs.push_back(mk(1, 1, 0, 12'h010, 16'h0000,  1, 0, 12'h020, 16'h0000,  0, 0));
        vecs.push_back(mk(0, 1, 0, 12'h010, 16'h0000,  1, 0, 12'h020, 16'h0000,  1, 0));
        vecs.push_back(mk(0, 1, 0, 12'h010, 16'h0000,  1, 0, 12'h020, 16'h0000,  0, 1));
        vecs.push_back(mk(0, 1, 0, 12'h010, 16'h0000,  1, 0, 12'h020, 16'h0000,  1, 0));
        vecs.push_back(mk(0, 1, 0, 12'h010, 16'h0000,  1, 0, 12'h020, 16'h0000,  0, 1));
        vecs.push_back(mk(0, 0, 0, 12'h000, 16'h0000,  0, 0, 12'h000, 16'h0000,  0, 0));
        vecs.push_back(mk(0, 1, 1, 12'h0A5, 16'h1234,  0, 0, 12'h000, 16'h0000,  1, 0));
        vecs.push_back(mk(0, 1, 0, 12'h0A5, 16'h0000,  0, 0, 12'h000, 16'h0000,  1, 0));
        vecs.push_back(mk(0, 0, 0, 12'h000, 16'h0000,  0, 0, 12'h000, 16'h0000,  0, 0));
        vecs.push_back(mk(0, 0, 0, 12'h000, 16'h0000,  0, 0, 12'h000, 16'h0000,  0, 0));
        vecs.push_back(mk(0, 1, 0, 12'h030, 16'h0000,  1, 0, 12'h040, 16'h0000,  0, 1));
        vecs.push_back(mk(0, 1, 0, 12'h030, 16'h0000,  0, 0, 12'h000, 16'h0000,  1, 0));
        vecs.push_back(mk(0, 0, 0, 12'h000, 16'h0000,  1, 0, 12'h020, 16'h0000,  0, 1));
        vecs.push_back(mk(0, 1, 0, 12'hFFF, 16'h0000,  1, 1, 12'hFFF, 16'hBEEF,  1, 0));
        vecs.push_back(mk(0, 1, 0, 12'hFFF, 16'h0000,  1, 1, 12'hFFF, 16'hBEEF,  0, 1));
        vecs.push_back(mk(0, 1, 0, 12'hFFF, 16'h0000,  0, 0, 12'h000, 16'h0000,  1, 0));
        vecs.push_back(mk(0, 0, 0, 12'h000, 16'h0000,  0, 0, 12'h000, 16'h0000,  0, 0));
        vecs.push_back(mk(0, 1, 0, 12'h010, 16'h0000,  0, 0, 12'h000, 16'h0000,  1, 0));
        vecs.push_back(mk(1, 1, 0, 12'h020, 16'h0000,  1, 0, 12'h030, 16'h0000,  0, 0));
        vecs.push_back(mk(1, 1, 0, 12'h020, 16'h0000,  1, 0, 12'h030, 16'h0000,  0, 0));
        vecs.push_back(mk(0, 1, 0, 12'h020, 16'h0000,  1, 0, 12'h030, 16'h0000,  1, 0));
        vecs.push_back(mk(0, 0, 0, 12'h000, 16'h0000,  1, 0, 12'h030, 16'h0000,  0, 1));
        vecs.push_back(mk(0, 0, 0, 12'h000, 16'h0000,  0, 0, 12'h000, 16'h0000,  0, 0));
        vecs.push_back(mk(0, 0, 0, 12'h000, 16'h0000,  0, 0, 12'h000, 16'h0000,  0, 0));

        @(posedge clk);
        #1;
        mem_init = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end
        check("sb_drained", vecs.size(), 32'(sb.size()), 32'd0);

        // Fixed priority: port 0 holds off port 1 for as long as it requests.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(mk(0, 1, 0, 12'h010, 16'h0000, 1, 0, 12'h020, 16'h0000, 1, 0));
            @(negedge clk);
            check("fp_p0_ack", k, 32'(fp_p0_ack), 32'd1);
            check("fp_p1_ack", k, 32'(fp_p1_ack), 32'd0);
            if (k > 0) begin
                check("fp_p0_rvalid", k, 32'(fp_p0_rvalid), 32'd1);
                check("fp_p0_rdata",  k, 32'(fp_p0_rdata),  32'(shadow[12'h010]));
            end
        end
        applyStimulus(mk(0, 0, 0, 12'h000, 16'h0000, 1, 0, 12'h020, 16'h0000, 0, 1));
        @(negedge clk);
        check("fp_p0_ack_drop", 4, 32'(fp_p0_ack),    32'd0);
        check("fp_p1_ack_drop", 4, 32'(fp_p1_ack),    32'd1);
        check("fp_p0_rv_last",  4, 32'(fp_p0_rvalid), 32'd1);
        applyStimulus(mk(0, 0, 0, 12'h000, 16'h0000, 0, 0, 12'h000, 16'h0000, 0, 0));
        @(negedge clk);
        check("fp_p1_rvalid",   5, 32'(fp_p1_rvalid), 32'd1);
        check("fp_p1_rdata",    5, 32'(fp_p1_rdata),  32'(shadow[12'h020]));
        check("fp_p0_rv_idle",  5, 32'(fp_p0_rvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
